// File: rtl/fetch_pkg.sv
// Shared fetch-queue types: JAL opcode, FSM state encoding, queue entry layout.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package fetch_pkg;

  // Major opcode of JAL, used by the optional predecode path.
  localparam logic [6:0] OPC_JAL = 7'b1101111;

  // Entry address fields are sized for the widest supported XLEN; narrower
  // builds zero-extend on write and slice on read.
  localparam int FQ_XLEN_MAX = 64;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fq_state_e;

  typedef struct packed {
    logic [31:0]            inst;
    logic [FQ_XLEN_MAX-1:0] pc;
    logic [FQ_XLEN_MAX-1:0] npc;
  } fq_entry_t;

  // J-type immediate (21 bits, LSB always zero), still to be sign-extended.
  function automatic logic [20:0] jal_imm(input logic [31:0] inst);
    return {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Fetch-queue storage: DEPTH entries, wrap pointers with an extra lap bit, occupancy count.
// Latency: a pushed entry appears at the head one cycle later; head is first-word-fall-through.
// Backpressure: push ignored when full, pop ignored when empty; clear wins over push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr_i,
  input  logic            push_i,
  input  fq_entry_t       push_dat_i,
  input  logic            pop_i,
  output fq_entry_t       head_dat_o,
  output logic [CW-1:0]   count_o
);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  fq_entry_t   mem_q [DEPTH];
  logic        full, empty, push_ok, pop_ok;

  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign push_ok = push_i && !full && !clr_i;
  assign pop_ok  = pop_i && !empty && !clr_i;

  assign head_dat_o = mem_q[rd_ptr_q[AW-1:0]];
  assign count_o    = CW'(wr_ptr_q - rd_ptr_q);

  // Pointer next-state: clear empties the queue, otherwise advance on push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: one-outstanding I-cache requests feeding an in-order queue. Macro: FETCH_JAL_PREDECODE_EN.
// Latency: response pushed on its arrival cycle, visible at head next cycle; flush takes effect same cycle.
// Backpressure: no request unless queue has space; head held until is_ready; rdy=0 freezes everything.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 16,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  output logic                       ic_req_valid,
  output logic [XLEN-1:0]            ic_req_pc,
  input  logic                       ic_req_ready,
  input  logic                       ic_rsp_valid,
  input  logic [31:0]                ic_rsp_inst,
  input  logic [XLEN-1:0]            ic_rsp_pc,
  output logic [XLEN-1:0]            bp_pc,
  input  logic                       bp_taken,
  input  logic [XLEN-1:0]            bp_target,
  output logic                       is_valid,
  input  logic                       is_ready,
  output logic [31:0]                is_inst,
  output logic [XLEN-1:0]            is_pc,
  output logic [XLEN-1:0]            is_pred_npc,
  input  logic                       flush,
  input  logic [XLEN-1:0]            flush_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);

  fq_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] npc;
  logic            flush_en, req_fire, rsp_fire, push, pop;
  fq_entry_t       push_dat, head_dat;
  logic            unused_hi;

  assign ic_req_pc = pc_q;
  assign bp_pc     = pc_q;

  // At most one request in flight, and only when the response is sure to fit.
  assign ic_req_valid = !rst && rdy && (state_q == FETCH) && (count < CW'(DEPTH));
  assign req_fire     = ic_req_valid && ic_req_ready;
  assign flush_en     = rdy && flush;
  // A response is consumed in WAIT (live) or DRAIN (stale) whenever unfrozen.
  assign rsp_fire     = rdy && ic_rsp_valid && (state_q != FETCH);
  assign push         = rsp_fire && (state_q == WAIT) && !flush;
  assign pop          = rdy && !flush && is_valid && is_ready;

  // Predicted next PC of the instruction being returned.
  always_comb begin
    npc = bp_taken ? bp_target : pc_q + XLEN'(4);
`ifdef FETCH_JAL_PREDECODE_EN
    if (ic_rsp_inst[6:0] == OPC_JAL) npc = ic_rsp_pc + XLEN'($signed(jal_imm(ic_rsp_inst)));
`endif
  end

  assign push_dat = '{inst: ic_rsp_inst,
                      pc:   FQ_XLEN_MAX'(ic_rsp_pc),
                      npc:  FQ_XLEN_MAX'(npc)};

  // Request FSM: a request accepted alongside a flush becomes stale and is drained.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   if (req_fire) state_d = flush_en ? DRAIN : WAIT;
      WAIT:    if (rsp_fire) state_d = FETCH;
               else if (flush_en) state_d = DRAIN;
      DRAIN:   if (rsp_fire) state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // Fetch PC: redirect on flush, otherwise follow the prediction of each pushed entry.
  always_comb begin
    pc_d = pc_q;
    if (flush_en)  pc_d = flush_pc;
    else if (push) pc_d = npc;
  end

  // State and PC registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (flush_en),
    .push_i     (push),
    .push_dat_i (push_dat),
    .pop_i      (pop),
    .head_dat_o (head_dat),
    .count_o    (count)
  );

  assign is_valid    = (count != '0);
  assign is_inst     = head_dat.inst;
  assign is_pc       = head_dat.pc[XLEN-1:0];
  assign is_pred_npc = head_dat.npc[XLEN-1:0];
  assign unused_hi   = ^{head_dat.pc, head_dat.npc};

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue against a queue-based reference model.
// Latency: checks every cycle at the falling edge.
// Backpressure: bench drives is_ready, ic_req_ready and rdy randomly.
`timescale 1ns/1ps
module tb_fetch_queue;
  localparam int XLEN  = 32;
  localparam int DEPTH = 16;

  logic              clk = 1'b0;
  logic              rst, rdy;
  logic              ic_req_valid, ic_req_ready, ic_rsp_valid;
  logic [XLEN-1:0]   ic_req_pc, ic_rsp_pc, bp_pc, bp_target, is_pc, is_pred_npc, flush_pc;
  logic [31:0]       ic_rsp_inst, is_inst;
  logic              bp_taken, is_valid, is_ready, flush;
  logic [4:0]        count;

  always #5 clk = ~clk;

  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .ic_req_valid(ic_req_valid), .ic_req_pc(ic_req_pc), .ic_req_ready(ic_req_ready),
    .ic_rsp_valid(ic_rsp_valid), .ic_rsp_inst(ic_rsp_inst), .ic_rsp_pc(ic_rsp_pc),
    .bp_pc(bp_pc), .bp_taken(bp_taken), .bp_target(bp_target),
    .is_valid(is_valid), .is_ready(is_ready), .is_inst(is_inst), .is_pc(is_pc),
    .is_pred_npc(is_pred_npc), .flush(flush), .flush_pc(flush_pc), .count(count)
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] npc;
  } ent_t;

  // Reference model: queue contents, fetch PC, and what the cache still owes us
  // (0 nothing, 1 a response to keep, 2 a response to throw away).
  ent_t        mq[$];
  logic [31:0] m_pc = 32'h0;
  int          m_out = 0;

  // Instruction cache model: one pending response after a random delay.
  bit          ic_pend = 0;
  int          ic_wait = 0;
  int          lat_max = 1;
  logic [31:0] ic_pc_q = 32'h0, ic_inst_q = 32'h0;
  bit          force_en = 0;
  logic [31:0] force_inst = 32'h0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_npc(input logic [31:0] inst, input logic [31:0] pc,
                                          input logic tk, input logic [31:0] tgt);
`ifdef FETCH_JAL_PREDECODE_EN
    logic [20:0] imm;
    imm = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    if (inst[6:0] == 7'h6F) return pc + {{11{imm[20]}}, imm};
`endif
    return tk ? tgt : pc + 32'd4;
  endfunction

  // One clock cycle: present the cache response, check outputs, advance the model.
  task automatic step(input bit full);
    bit          fire, rsp, exp_rv;
    logic [31:0] req_pc, r;
    ent_t        e;
    ic_rsp_valid = ic_pend && (ic_wait == 0);
    ic_rsp_pc    = ic_pc_q;
    ic_rsp_inst  = ic_inst_q;
    #1;
    exp_rv = !rst && rdy && (m_out == 0) && (mq.size() < DEPTH);
    chk("req_vld", ic_req_valid, exp_rv);
    if (full) begin
      chk("req_pc", ic_req_pc, m_pc);
      chk("bp_pc", bp_pc, m_pc);
      chk("count", count, mq.size());
      chk("is_valid", is_valid, mq.size() != 0);
      if (mq.size() != 0) begin
        chk("is_inst", is_inst, mq[0].inst);
        chk("is_pc", is_pc, mq[0].pc);
        chk("is_npc", is_pred_npc, mq[0].npc);
      end
    end
    fire   = exp_rv && ic_req_ready;
    rsp    = ic_rsp_valid;
    req_pc = m_pc;
    if (rst) begin
      mq.delete();
      m_pc  = 32'h0;
      m_out = 0;
    end else if (rdy) begin
      if (flush) begin
        mq.delete();
        m_pc = flush_pc;
        if (fire)             m_out = 2;
        else if (rsp)         m_out = 0;
        else if (m_out != 0)  m_out = 2;
      end else begin
        if (is_ready && mq.size() != 0) void'(mq.pop_front());
        if (rsp) begin
          if (m_out == 1) begin
            e.inst = ic_rsp_inst;
            e.pc   = ic_rsp_pc;
            e.npc  = ref_npc(ic_rsp_inst, m_pc, bp_taken, bp_target);
            mq.push_back(e);
            m_pc = e.npc;
          end
          m_out = 0;
        end
        if (fire) m_out = 1;
      end
    end
    if (rst) begin
      ic_pend = 0;
    end else begin
      if (rsp && rdy) ic_pend = 0;
      else if (ic_pend && ic_wait > 0) ic_wait--;
      if (fire) begin
        ic_pend = 1;
        ic_wait = $urandom_range(lat_max - 1, 0);
        ic_pc_q = req_pc;
        if (force_en) begin
          ic_inst_q = force_inst;
          force_en  = 0;
        end else begin
          r = $urandom();
          ic_inst_q = ($urandom_range(5, 0) == 0) ? {r[31:7], 7'h6F} : r;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] exp_jal;
    int          guard;
    rst = 1; rdy = 1; ic_req_ready = 1; bp_taken = 0; bp_target = 32'h0;
    is_ready = 0; flush = 0; flush_pc = 32'h0;
    ic_rsp_valid = 0; ic_rsp_inst = 32'h0; ic_rsp_pc = 32'h0;
    @(negedge clk);
    step(0);
    step(1);
    rst = 0;

    // Fill: cache answers one cycle after each request, nothing issued.
    lat_max = 1;
    repeat (40) step(1);
    chk("fill_count", count, DEPTH);
    chk("fill_req_vld", ic_req_valid, 1'b0);

    // One pop from a full queue, then refill while popping every cycle.
    is_ready = 1;
    step(1);
    is_ready = 0;
    chk("pop_count", count, DEPTH - 1);
    is_ready = 1;
    repeat (6) step(1);
    is_ready = 0;

    // Freeze for three cycles mid-stream.
    rdy = 0;
    repeat (3) step(1);
    rdy = 1;
    repeat (4) step(1);

    // Randomized traffic with flushes, stalls, prediction and one reset.
    lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      rst          = (i == 1500);
      rdy          = ($urandom_range(7, 0) != 0);
      is_ready     = $urandom_range(1, 0);
      ic_req_ready = ($urandom_range(3, 0) != 0);
      bp_taken     = ($urandom_range(3, 0) == 0);
      bp_target    = $urandom() & 32'hFFFF_FFFC;
      flush        = ($urandom_range(19, 0) == 0);
      flush_pc     = $urandom() & 32'hFFFF_FFFC;
      step(1);
    end
    rst = 0;

    // JAL at 0x40 with immediate +0x100, predictor not taken.
    rdy = 1; is_ready = 0; bp_taken = 0; ic_req_ready = 1;
    flush = 1; flush_pc = 32'h40;
    step(1);
    flush = 0;
    force_en = 1;
    force_inst = 32'h1000_006F;
    guard = 0;
    while (mq.size() == 0 && guard < 20) begin
      step(1);
      guard++;
    end
`ifdef FETCH_JAL_PREDECODE_EN
    exp_jal = 32'h140;
`else
    exp_jal = 32'h44;
`endif
    chk("jal_count", count, 1);
    chk("jal_pc", is_pc, 32'h40);
    chk("jal_npc", is_pred_npc, exp_jal);
    chk("jal_next_req", ic_req_pc, exp_jal);
    step(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
